tlb_array: RTL and testbench

//  Fully-associative LoongArch TLB that serves the WB stage's TLB commands (tlbwr/tlbfill

---
 rtl/tlb_array.sv | 251 +++++++++++++++++++++++++
 tb/tb_tlb_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array.sv
// tlb_array: fully-associative LoongArch TLB, TLBNUM entries.
//   Two combinational search ports:
//     s0: instruction fetch.
//     s1: load/store; also supplies the invtlb operands.
//   One registered write port (tlbwr/tlbfill).
//   One combinational read port (tlbrd).
//   invtlb clears E on the selected entries.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   s{0,1}_vppn/_va_bit12/_asid search key
//   s{0,1}_found/_index/_ppn/_ps/_plv/_mat/_d/_v   search result (all 0 on miss)
//   invtlb_valid, invtlb_op     invalidate command
//   we, w_index, w_*            entry write
//   r_index, r_*                entry read
module tlb_array #(
   parameter int TLBNUM = 16,
   parameter int IDXW   = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [18:0]     s0_vppn,
   input  logic            s0_va_bit12,
   input  logic [9:0]      s0_asid,
   output logic            s0_found,
   output logic [IDXW-1:0] s0_index,
   output logic [19:0]     s0_ppn,
   output logic [5:0]      s0_ps,
   output logic [1:0]      s0_plv,
   output logic [1:0]      s0_mat,
   output logic            s0_d,
   output logic            s0_v,
   input  logic [18:0]     s1_vppn,
   input  logic            s1_va_bit12,
   input  logic [9:0]      s1_asid,
   output logic            s1_found,
   output logic [IDXW-1:0] s1_index,
   output logic [19:0]     s1_ppn,
   output logic [5:0]      s1_ps,
   output logic [1:0]      s1_plv,
   output logic [1:0]      s1_mat,
   output logic            s1_d,
   output logic            s1_v,
   input  logic            invtlb_valid,
   input  logic [4:0]      invtlb_op,
   input  logic            we,
   input  logic [IDXW-1:0] w_index,
   input  logic            w_e,
   input  logic            w_g,
   input  logic [18:0]     w_vppn,
   input  logic [5:0]      w_ps,
   input  logic [9:0]      w_asid,
   input  logic [19:0]     w_ppn0,
   input  logic [19:0]     w_ppn1,
   input  logic [1:0]      w_plv0,
   input  logic [1:0]      w_plv1,
   input  logic [1:0]      w_mat0,
   input  logic [1:0]      w_mat1,
   input  logic            w_d0,
   input  logic            w_d1,
   input  logic            w_v0,
   input  logic            w_v1,
   input  logic [IDXW-1:0] r_index,
   output logic            r_e,
   output logic            r_g,
   output logic [18:0]     r_vppn,
   output logic [5:0]      r_ps,
   output logic [9:0]      r_asid,
   output logic [19:0]     r_ppn0,
   output logic [19:0]     r_ppn1,
   output logic [1:0]      r_plv0,
   output logic [1:0]      r_plv1,
   output logic [1:0]      r_mat0,
   output logic [1:0]      r_mat1,
   output logic            r_d0,
   output logic            r_d1,
   output logic            r_v0,
   output logic            r_v1
);

   // Entry storage
   logic [TLBNUM-1:0] e_reg, g_reg, d0_reg, d1_reg, v0_reg, v1_reg;
   logic [18:0]       vppn_reg [TLBNUM];
   logic [5:0]        ps_reg   [TLBNUM];
   logic [9:0]        asid_reg [TLBNUM];
   logic [19:0]       ppn0_reg [TLBNUM];
   logic [19:0]       ppn1_reg [TLBNUM];
   logic [1:0]        plv0_reg [TLBNUM];
   logic [1:0]        plv1_reg [TLBNUM];
   logic [1:0]        mat0_reg [TLBNUM];
   logic [1:0]        mat1_reg [TLBNUM];

   // Only 4KB (12) and 2MB (21) pages are decoded; any other ps never matches.
   logic [TLBNUM-1:0] ps12, ps21;
   logic [TLBNUM-1:0] inv_hit;

   genvar gi, gp;
   generate
      for (gi = 0; gi < TLBNUM; gi++) begin : gen_ps
         assign ps12[gi] = (ps_reg[gi] == 6'd12);
         assign ps21[gi] = (ps_reg[gi] == 6'd21);
      end

      for (gp = 0; gp < 2; gp++) begin : gen_port
         logic [18:0]       vppn;
         logic              bit12;
         logic [9:0]        asid;
         logic [TLBNUM-1:0] vppn_eq, asid_eq, hit;
         logic              found, d, v;
         logic [IDXW-1:0]   index;
         logic [19:0]       ppn;
         logic [5:0]        ps;
         logic [1:0]        plv, mat;

         assign vppn  = (gp == 0) ? s0_vppn     : s1_vppn;
         assign bit12 = (gp == 0) ? s0_va_bit12 : s1_va_bit12;
         assign asid  = (gp == 0) ? s0_asid     : s1_asid;

         for (gi = 0; gi < TLBNUM; gi++) begin : gen_cmp
            assign vppn_eq[gi] = (ps12[gi] && vppn_reg[gi] == vppn) ||
                                 (ps21[gi] && vppn_reg[gi][18:9] == vppn[18:9]);
            assign asid_eq[gi] = (asid_reg[gi] == asid);
            assign hit[gi]     = e_reg[gi] && (g_reg[gi] || asid_eq[gi]) && vppn_eq[gi];
         end

         // Scan from the top so the lowest matching index is the last assignment.
         always_comb begin
            logic odd;
            odd   = 1'b0;
            found = 1'b0;
            index = '0;
            ppn   = '0;
            ps    = '0;
            plv   = '0;
            mat   = '0;
            d     = 1'b0;
            v     = 1'b0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
               if (hit[i]) begin
                  odd   = ps21[i] ? vppn[8] : bit12;
                  found = 1'b1;
                  index = IDXW'(i);
                  ps    = ps_reg[i];
                  ppn   = odd ? ppn1_reg[i] : ppn0_reg[i];
                  plv   = odd ? plv1_reg[i] : plv0_reg[i];
                  mat   = odd ? mat1_reg[i] : mat0_reg[i];
                  d     = odd ? d1_reg[i]   : d0_reg[i];
                  v     = odd ? v1_reg[i]   : v0_reg[i];
               end
            end
         end
      end

      // invtlb selection uses the s1 comparators (operands arrive on s1).
      for (gi = 0; gi < TLBNUM; gi++) begin : gen_inv
         always_comb begin
            case (invtlb_op)
               5'd0, 5'd1: inv_hit[gi] = 1'b1;
               5'd2:       inv_hit[gi] = g_reg[gi];
               5'd3:       inv_hit[gi] = ~g_reg[gi];
               5'd4:       inv_hit[gi] = ~g_reg[gi] & gen_port[1].asid_eq[gi];
               5'd5:       inv_hit[gi] = ~g_reg[gi] & gen_port[1].asid_eq[gi] &
                                         gen_port[1].vppn_eq[gi];
               5'd6:       inv_hit[gi] = (g_reg[gi] | gen_port[1].asid_eq[gi]) &
                                         gen_port[1].vppn_eq[gi];
               default:    inv_hit[gi] = 1'b0;
            endcase
         end
      end
   endgenerate

   // invtlb is applied before the write so a same-cycle write sets E to w_e.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_reg  <= '0;
         g_reg  <= '0;
         d0_reg <= '0;
         d1_reg <= '0;
         v0_reg <= '0;
         v1_reg <= '0;
         for (int i = 0; i < TLBNUM; i++) begin
            vppn_reg[i] <= '0;
            ps_reg[i]   <= '0;
            asid_reg[i] <= '0;
            ppn0_reg[i] <= '0;
            ppn1_reg[i] <= '0;
            plv0_reg[i] <= '0;
            plv1_reg[i] <= '0;
            mat0_reg[i] <= '0;
            mat1_reg[i] <= '0;
         end
      end else begin
         if (invtlb_valid) begin
            for (int i = 0; i < TLBNUM; i++) begin
               if (inv_hit[i]) e_reg[i] <= 1'b0;
            end
         end
         if (we) begin
            e_reg[w_index]    <= w_e;
            g_reg[w_index]    <= w_g;
            d0_reg[w_index]   <= w_d0;
            d1_reg[w_index]   <= w_d1;
            v0_reg[w_index]   <= w_v0;
            v1_reg[w_index]   <= w_v1;
            vppn_reg[w_index] <= w_vppn;
            ps_reg[w_index]   <= w_ps;
            asid_reg[w_index] <= w_asid;
            ppn0_reg[w_index] <= w_ppn0;
            ppn1_reg[w_index] <= w_ppn1;
            plv0_reg[w_index] <= w_plv0;
            plv1_reg[w_index] <= w_plv1;
            mat0_reg[w_index] <= w_mat0;
            mat1_reg[w_index] <= w_mat1;
         end
      end
   end

   assign s0_found = gen_port[0].found;
   assign s0_index = gen_port[0].index;
   assign s0_ppn   = gen_port[0].ppn;
   assign s0_ps    = gen_port[0].ps;
   assign s0_plv   = gen_port[0].plv;
   assign s0_mat   = gen_port[0].mat;
   assign s0_d     = gen_port[0].d;
   assign s0_v     = gen_port[0].v;
   assign s1_found = gen_port[1].found;
   assign s1_index = gen_port[1].index;
   assign s1_ppn   = gen_port[1].ppn;
   assign s1_ps    = gen_port[1].ps;
   assign s1_plv   = gen_port[1].plv;
   assign s1_mat   = gen_port[1].mat;
   assign s1_d     = gen_port[1].d;
   assign s1_v     = gen_port[1].v;

   // Raw entry contents; E=0 entries are not masked here.
   assign r_e    = e_reg[r_index];
   assign r_g    = g_reg[r_index];
   assign r_vppn = vppn_reg[r_index];
   assign r_ps   = ps_reg[r_index];
   assign r_asid = asid_reg[r_index];
   assign r_ppn0 = ppn0_reg[r_index];
   assign r_ppn1 = ppn1_reg[r_index];
   assign r_plv0 = plv0_reg[r_index];
   assign r_plv1 = plv1_reg[r_index];
   assign r_mat0 = mat0_reg[r_index];
   assign r_mat1 = mat1_reg[r_index];
   assign r_d0   = d0_reg[r_index];
   assign r_d1   = d1_reg[r_index];
   assign r_v0   = v0_reg[r_index];
   assign r_v1   = v1_reg[r_index];

endmodule

// File: tb/tb_tlb_array.sv
module tb_tlb_array;
   logic        clk, resetn;
   logic [18:0] s0_vppn, s1_vppn;
   logic        s0_va_bit12, s1_va_bit12;
   logic [9:0]  s0_asid, s1_asid;
   logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
   logic [3:0]  s0_index, s1_index;
   logic [19:0] s0_ppn, s1_ppn;
   logic [5:0]  s0_ps, s1_ps;
   logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
   logic        invtlb_valid;
   logic [4:0]  invtlb_op;
   logic        we, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
   logic [3:0]  w_index, r_index;
   logic [18:0] w_vppn, r_vppn;
   logic [5:0]  w_ps, r_ps;
   logic [9:0]  w_asid, r_asid;
   logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
   logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1;
   logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
   logic        r_e, r_g, r_d0, r_d1, r_v0, r_v1;

   int checks = 0;
   int failures = 0;

   tlb_array #(.TLBNUM(16), .IDXW(4)) dut (
      .clk(clk), .resetn(resetn),
      .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
      .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
      .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
      .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
      .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
      .we(we), .w_index(w_index), .w_e(w_e), .w_g(w_g),
      .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
      .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1),
      .w_mat0(w_mat0), .w_mat1(w_mat1), .w_d0(w_d0), .w_d1(w_d1),
      .w_v0(w_v0), .w_v1(w_v1),
      .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_vppn(r_vppn), .r_ps(r_ps),
      .r_asid(r_asid), .r_ppn0(r_ppn0), .r_ppn1(r_ppn1),
      .r_plv0(r_plv0), .r_plv1(r_plv1), .r_mat0(r_mat0), .r_mat1(r_mat1),
      .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Fixed attribute pattern: even page plv=0 mat=1, odd page plv=3 mat=2.
   task automatic set_w(input logic [3:0] idx, input logic e, input logic g,
                        input logic [18:0] vppn, input logic [5:0] ps,
                        input logic [9:0] asid, input logic [19:0] p0, input logic [19:0] p1);
      w_index = idx; w_e = e; w_g = g; w_vppn = vppn; w_ps = ps; w_asid = asid;
      w_ppn0 = p0; w_ppn1 = p1; w_plv0 = 2'd0; w_plv1 = 2'd3;
      w_mat0 = 2'd1; w_mat1 = 2'd2; w_d0 = 1'b1; w_d1 = 1'b1; w_v0 = 1'b1; w_v1 = 1'b1;
   endtask

   task automatic wr(input logic [3:0] idx, input logic g, input logic [18:0] vppn,
                     input logic [5:0] ps, input logic [9:0] asid,
                     input logic [19:0] p0, input logic [19:0] p1);
      @(negedge clk);
      set_w(idx, 1'b1, g, vppn, ps, asid, p0, p1);
      we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      $display("write idx=%0d vppn=0x%0h ps=%0d asid=0x%0h g=%0d", idx, vppn, ps, asid, g);
   endtask

   task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
      @(negedge clk);
      invtlb_op = op; s1_asid = asid; s1_vppn = vppn; invtlb_valid = 1'b1;
      @(negedge clk);
      invtlb_valid = 1'b0;
      $display("invtlb op=%0d asid=0x%0h vppn=0x%0h", op, asid, vppn);
   endtask

   task automatic srch0(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
      s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid;
      #1;
      $display("s0 search vppn=0x%0h b12=%0d asid=0x%0h -> found=%0d idx=%0d ppn=0x%0h",
               vppn, b12, asid, s0_found, s0_index, s0_ppn);
   endtask

   initial begin
      resetn = 1'b0; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = '0; r_index = '0;
      s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
      s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
      set_w(4'd0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
      w_plv1 = '0; w_mat0 = '0; w_mat1 = '0; w_d0 = 0; w_d1 = 0; w_v0 = 0; w_v1 = 0;
      repeat (2) @(negedge clk);
      chk("rst_s0_found", 32'(s0_found), 32'd0);
      chk("rst_s1_found", 32'(s1_found), 32'd0);
      chk("rst_r_e", 32'(r_e), 32'd0);
      chk("rst_s0_ppn", 32'(s0_ppn), 32'd0);
      resetn = 1'b1;

      // 4KB page, non-global
      wr(4'd3, 1'b0, 19'h12345, 6'd12, 10'h005, 20'hAAAAA, 20'hBBBBB);
      srch0(19'h12345, 1'b1, 10'h005);
      chk("p12_found", 32'(s0_found), 32'd1);
      chk("p12_index", 32'(s0_index), 32'd3);
      chk("p12_ppn_odd", 32'(s0_ppn), 32'hBBBBB);
      chk("p12_ps", 32'(s0_ps), 32'd12);
      chk("p12_plv_odd", 32'(s0_plv), 32'd3);
      chk("p12_mat_odd", 32'(s0_mat), 32'd2);
      chk("p12_dv", {30'd0, s0_d, s0_v}, 32'd3);
      srch0(19'h12345, 1'b0, 10'h005);
      chk("p12_ppn_even", 32'(s0_ppn), 32'hAAAAA);
      chk("p12_plv_even", 32'(s0_plv), 32'd0);
      srch0(19'h12345, 1'b1, 10'h006);
      chk("p12_asid_miss", 32'(s0_found), 32'd0);
      chk("miss_ppn_zero", 32'(s0_ppn), 32'd0);
      chk("miss_ps_zero", 32'(s0_ps), 32'd0);
      srch0(19'h12344, 1'b1, 10'h005);
      chk("p12_vppn_miss", 32'(s0_found), 32'd0);
      s1_vppn = 19'h12345; s1_va_bit12 = 1'b0; s1_asid = 10'h005; #1;
      chk("s1_found", 32'(s1_found), 32'd1);
      chk("s1_ppn", 32'(s1_ppn), 32'hAAAAA);

      // 2MB page, global
      wr(4'd7, 1'b1, 19'h40000, 6'd21, 10'h3FF, 20'h00456, 20'h00123);
      srch0(19'h401FF, 1'b0, 10'h022);
      chk("p21_found", 32'(s0_found), 32'd1);
      chk("p21_index", 32'(s0_index), 32'd7);
      chk("p21_ppn_odd", 32'(s0_ppn), 32'h00123);
      chk("p21_ps", 32'(s0_ps), 32'd21);
      srch0(19'h400FF, 1'b1, 10'h100);
      chk("p21_ppn_even", 32'(s0_ppn), 32'h00456);
      srch0(19'h40200, 1'b0, 10'h022);
      chk("p21_hi_miss", 32'(s0_found), 32'd0);

      // illegal page size never matches
      wr(4'd1, 1'b1, 19'h11111, 6'd13, 10'h000, 20'h1, 20'h2);
      srch0(19'h11111, 1'b0, 10'h000);
      chk("ps13_miss", 32'(s0_found), 32'd0);

      // duplicate tag: lowest index wins
      wr(4'd9, 1'b0, 19'h55555, 6'd12, 10'h005, 20'h99999, 20'h99999);
      wr(4'd2, 1'b0, 19'h55555, 6'd12, 10'h005, 20'h22222, 20'h22222);
      wr(4'd10, 1'b0, 19'h0AAAA, 6'd12, 10'h006, 20'h0A0A0, 20'h0B0B0);
      srch0(19'h55555, 1'b0, 10'h005);
      chk("dup_index", 32'(s0_index), 32'd2);
      chk("dup_ppn", 32'(s0_ppn), 32'h22222);

      // tlbrd
      r_index = 4'd3; #1;
      chk("rd_vppn", 32'(r_vppn), 32'h12345);
      chk("rd_ps", 32'(r_ps), 32'd12);
      chk("rd_ppn0", 32'(r_ppn0), 32'hAAAAA);
      chk("rd_ppn1", 32'(r_ppn1), 32'hBBBBB);
      chk("rd_asid", 32'(r_asid), 32'h005);
      chk("rd_eg", {30'd0, r_e, r_g}, 32'd2);

      // invtlb op 2: global entries 1 and 7 only
      inv(5'd2, 10'h000, 19'h0);
      r_index = 4'd7; #1;
      chk("op2_idx7_e", 32'(r_e), 32'd0);
      chk("op2_idx7_vppn_kept", 32'(r_vppn), 32'h40000);
      r_index = 4'd1; #1;
      chk("op2_idx1_e", 32'(r_e), 32'd0);
      r_index = 4'd3; #1;
      chk("op2_idx3_kept", 32'(r_e), 32'd1);
      srch0(19'h401FF, 1'b0, 10'h022);
      chk("op2_p21_miss", 32'(s0_found), 32'd0);

      // invtlb op 4 with asid 5: idx 2,3,9 cleared, idx 10 (asid 6) kept
      inv(5'd4, 10'h005, 19'h0);
      r_index = 4'd3; #1;
      chk("op4_idx3_e", 32'(r_e), 32'd0);
      r_index = 4'd2; #1;
      chk("op4_idx2_e", 32'(r_e), 32'd0);
      r_index = 4'd10; #1;
      chk("op4_idx10_kept", 32'(r_e), 32'd1);
      srch0(19'h12345, 1'b1, 10'h005);
      chk("op4_idx3_miss", 32'(s0_found), 32'd0);

      // unknown op: no effect
      inv(5'd7, 10'h000, 19'h0);
      r_index = 4'd10; #1;
      chk("op7_noeffect", 32'(r_e), 32'd1);

      // write idx5 together with invtlb op 0; search sees pre-write state
      @(negedge clk);
      set_w(4'd5, 1'b1, 1'b0, 19'h00777, 6'd12, 10'h007, 20'h77777, 20'h77777);
      we = 1'b1; invtlb_op = 5'd0; invtlb_valid = 1'b1;
      srch0(19'h0AAAA, 1'b0, 10'h006);
      chk("same_cyc_old_found", 32'(s0_found), 32'd1);
      chk("same_cyc_old_index", 32'(s0_index), 32'd10);
      srch0(19'h00777, 1'b0, 10'h007);
      chk("same_cyc_new_miss", 32'(s0_found), 32'd0);
      @(negedge clk);
      we = 1'b0; invtlb_valid = 1'b0;
      $display("write idx=5 with invtlb op=0 in same cycle");
      for (int i = 0; i < 16; i++) begin
         r_index = 4'(i); #1;
         chk($sformatf("op0_e_idx%0d", i), 32'(r_e), (i == 5) ? 32'd1 : 32'd0);
      end
      srch0(19'h00777, 1'b0, 10'h007);
      chk("after_new_found", 32'(s0_found), 32'd1);
      chk("after_new_index", 32'(s0_index), 32'd5);
      srch0(19'h0AAAA, 1'b0, 10'h006);
      chk("after_old_miss", 32'(s0_found), 32'd0);

      // mid-run async reset
      s0_vppn = 19'h00777; s0_asid = 10'h007;
      s1_vppn = 19'h00777; s1_asid = 10'h007; r_index = 4'd5;
      @(posedge clk); #2;
      resetn = 1'b0; #1;
      chk("arst_s0_found", 32'(s0_found), 32'd0);
      chk("arst_s1_found", 32'(s1_found), 32'd0);
      chk("arst_r_vppn", 32'(r_vppn), 32'd0);
      for (int i = 0; i < 16; i++) begin
         r_index = 4'(i); #1;
         chk($sformatf("arst_e_idx%0d", i), 32'(r_e), 32'd0);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
